// File: rtl/seg_display_mux.sv
// Stopwatch display driver: converts binary minutes/seconds to BCD and
// scans them onto a 4-digit common-anode display, blinking one field in adjust mode.
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adjust,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt;
  logic [1:0]    didx;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [5:0] field;
  logic [3:0] nib;
  logic       dash;
  logic       blank;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Digits 2/3 carry minutes, 0/2 are ones positions.
  always_comb begin
    field    = didx[1] ? minutes : seconds;
    dash     = field > 6'd59;
    nib      = didx[0] ? 4'(field / 6'd10) : 4'(field % 6'd10);
    seg_next = dash ? 7'b0111111 : enc(nib);
    dp_next  = (didx != 2'd2);
    blank    = adjust & phase & (didx[1] ^ sel);
    an_next  = blank ? 4'b1111 : ~(4'b0001 << didx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      didx <= 2'd0;
    end else if (rcnt == R_LAST) begin
      rcnt <= '0;
      didx <= didx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Held at zero outside adjust so the display never stays blanked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (!adjust) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == B_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: driver pushes expected outputs
// from an arithmetic reference model, monitor pops and compares each edge.
module tb_seg_display_mux;

  localparam int R = 4;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       adjust = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  exp_t got;
  int   total = 0;
  int   bad = 0;
  int   k = 0;
  int   a = 0;

  logic [6:0] codes [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  seg_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset), .minutes(minutes), .seconds(seconds),
    .adjust(adjust), .sel(sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // k = edges since reset release, a = consecutive edges spent in adjust.
  task automatic step(input logic r, input logic [5:0] m, input logic [5:0] s,
                      input logic adj, input logic sl);
    exp_t e;
    int   d;
    int   v;
    int   dig;
    bit   ph;
    @(negedge clk);
    reset = r; minutes = m; seconds = s; adjust = adj; sel = sl;
    if (r) begin
      e = '{4'b1111, 7'b1111111, 1'b1};
      k = 0;
      a = 0;
    end else begin
      d   = (k / R) % 4;
      v   = (d >= 2) ? int'(m) : int'(s);
      ph  = ((a / B) % 2) == 1;
      dig = (d % 2 == 1) ? v / 10 : v % 10;
      e.seg = (v > 59) ? 7'b0111111 : codes[dig];
      e.dp  = (d != 2);
      if (adj && ph && ((d >= 2) == !sl)) e.an = 4'b1111;
      else e.an = ~(4'b0001 << d);
      k++;
      a = adj ? a + 1 : 0;
    end
    q.push_back(e);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: an=%b seg=%b dp=%b expected 1111 1111111 1",
               an, seg, dp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        got = q.pop_front();
        total++;
        if ({an, seg, dp} !== got) begin
          bad++;
          $display("FAIL out t=%0t: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   $time, an, seg, dp, got.an, got.seg, got.dp);
        end
      end
    end
  end

  initial begin
    logic [5:0] m;
    logic [5:0] s;
    logic       adj;
    logic       sl;
    logic       r;
    repeat (3) step(1, 12, 34, 0, 0);
    repeat (20) step(0, 12, 34, 0, 0);
    repeat (16) step(0, 59, 0, 0, 0);
    repeat (16) step(0, 59, 62, 0, 0);
    repeat (40) step(0, 12, 34, 1, 1);
    for (int i = 0; i < 40 && ((a / B) % 2) == 0; i++) step(0, 12, 34, 1, 1);
    repeat (16) step(0, 12, 34, 0, 1);
    repeat (20) step(0, 45, 7, 1, 0);
    for (int i = 0; i < 16 && ((k / R) % 4) != 3; i++) step(0, 45, 7, 0, 0);
    async_reset_check();
    step(1, 45, 7, 0, 0);
    repeat (12) step(0, 45, 7, 0, 0);
    m = 6'd0; s = 6'd0; adj = 1'b0; sl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) m = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) s = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sl = ~sl;
      r = ($urandom_range(0, 199) == 0);
      step(r, m, s, adj, sl);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
